// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one operand bit per cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we_hi,
  input  logic             hilo_we_lo,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               bzero_q, bzero_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               is_signed, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_signed = ~op[0];
    is_div    = op[1];
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: work holds {partial product upper half, remaining multiplier bits}.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // Divide: work holds {remainder, dividend/quotient}; MSB of the diff is the borrow.
    div_shift = work_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

    prod_fix = qsign_q ? -work_q : work_q;
    quo_fix  = qsign_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = rsign_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    work_d  = work_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    bzero_d = bzero_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (hilo_we_hi) hi_d = hilo_wd;
        if (hilo_we_lo) lo_d = hilo_wd;
        if (start) begin
          state_d = StCalc;
          op_d    = op;
          araw_d  = a;
          qsign_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d = is_signed & is_div & a[WIDTH-1];
          bzero_d = (b == '0);
          dz_d    = 1'b0;
          cnt_d   = CntW'(WIDTH);
          if (is_div) begin
            work_d = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            work_d = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      StCalc: begin
        work_d = op_q[1] ? div_next : mul_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (bzero_q) begin
            lo_d = '1;
            hi_d = araw_q;
            dz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      work_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      bzero_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      work_q  <= work_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      bzero_q <= bzero_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, hilo_wd = '0;
  logic         hilo_we_hi = 1'b0, hilo_we_lo = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int failed = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_we_hi(hilo_we_hi), .hilo_we_lo(hilo_we_lo), .hilo_wd(hilo_wd),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncated to W bits.
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] eh, output logic [W-1:0] el,
                                output logic edz);
    logic signed [63:0] sa, sb, sr;
    logic [63:0] r;
    sa  = 64'(signed'(ma));
    sb  = 64'(signed'(mb));
    edz = 1'b0;
    if (mop[1] && mb == '0) begin
      el  = '1;
      eh  = ma;
      edz = 1'b1;
    end else begin
      case (mop)
        2'b00: begin sr = sa * sb; eh = sr[63:32]; el = sr[31:0]; end
        2'b01: begin r = {32'b0, ma} * {32'b0, mb}; eh = r[63:32]; el = r[31:0]; end
        2'b10: begin sr = sa / sb; el = sr[31:0]; sr = sa % sb; eh = sr[31:0]; end
        default: begin el = ma / mb; eh = ma % mb; end
      endcase
    end
  endfunction

  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    op = iop; a = ia; b = ib; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge just after the accept edge.
  task automatic finish_op(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edz, input bit interfere);
    logic [W-1:0] ph, pl;
    int cyc;
    bit stable;
    ph = hi; pl = lo; stable = 1'b1; cyc = 0;
    chk({tag, " dz_clear_at_accept"}, W'(div_zero), '0);
    while (!done && cyc < 100) begin
      if (interfere && cyc == 5) begin
        start = 1'b1; hilo_we_hi = 1'b1; hilo_wd = 32'h1234;
      end else begin
        start = 1'b0; hilo_we_hi = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!done && (hi !== ph || lo !== pl || busy !== 1'b1)) stable = 1'b0;
    end
    start = 1'b0; hilo_we_hi = 1'b0;
    chk({tag, " latency"}, W'(cyc), W'(33));
    chk({tag, " stable_busy"}, W'(stable), W'(1));
    chk({tag, " busy_after"}, W'(busy), '0);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " div_zero"}, W'(div_zero), W'(edz));
    @(posedge clk); @(negedge clk);
    chk({tag, " done_single"}, W'(done), '0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] rop, input logic [W-1:0] ra,
                        input logic [W-1:0] rb, input bit interfere);
    logic [W-1:0] eh, el;
    logic edz;
    model(rop, ra, rb, eh, el, edz);
    issue(rop, ra, rb);
    finish_op(tag, eh, el, edz, interfere);
  endtask

  initial begin
    bit quiet;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("rst hi", hi, '0);
    chk("rst lo", lo, '0);
    chk("rst busy", W'(busy), '0);
    chk("rst done", W'(done), '0);
    chk("rst dz", W'(div_zero), '0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
    run_op("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("mult_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("divu_7d0", 2'b11, 32'd7, 32'd0, 1'b0);
    run_op("divu_7d2", 2'b11, 32'd7, 32'd2, 1'b0);
    run_op("div_m9d0", 2'b10, 32'hFFFFFFF7, 32'd0, 1'b0);
    run_op("mult_interfere", 2'b00, 32'd1000, 32'hFFFFFF00, 1'b1);

    // Reset in the middle of an operation.
    issue(2'b01, 32'h12345, 32'h777);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst busy", W'(busy), '0);
    chk("midrst hi", hi, '0);
    chk("midrst lo", lo, '0);
    chk("midrst done", W'(done), '0);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("midrst no_done", W'(quiet), W'(1));

    // MTHI/MTLO alone, then together with a start.
    hilo_we_hi = 1'b1; hilo_we_lo = 1'b1; hilo_wd = 32'hA5A5A5A5;
    @(posedge clk); @(negedge clk);
    hilo_we_hi = 1'b0; hilo_we_lo = 1'b0;
    chk("mt hi", hi, 32'hA5A5A5A5);
    chk("mt lo", lo, 32'hA5A5A5A5);
    chk("mt done", W'(done), '0);
    hilo_we_hi = 1'b1; hilo_we_lo = 1'b0; hilo_wd = 32'h5A5A0001;
    @(posedge clk); @(negedge clk);
    hilo_we_hi = 1'b0;
    chk("mthi_only hi", hi, 32'h5A5A0001);
    chk("mthi_only lo", lo, 32'hA5A5A5A5);
    hilo_we_hi = 1'b1; hilo_we_lo = 1'b1; hilo_wd = 32'hA5A5A5A5;
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; hilo_we_hi = 1'b0; hilo_we_lo = 1'b0;
    chk("mtstart hi", hi, 32'hA5A5A5A5);
    chk("mtstart lo", lo, 32'hA5A5A5A5);
    chk("mtstart busy", W'(busy), W'(1));
    finish_op("mtstart_res", 32'd0, 32'd6, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h80000000;
        3: rb = 32'h80000000;
        4: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath; extends the combinational ALU with MULT, MULTU, DIV, DIVU and MTHI/MTLO.
- One operand bit is processed per cycle: shift-add for multiply, restoring division for divide.
- Sits beside the ALU. The controller stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width (>=4); the iteration counter is clog2(WIDTH)+1 bits.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
start  input  1  request an operation; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
hilo_we_hi  input  1  MTHI write enable
hilo_we_lo  input  1  MTLO write enable
hilo_wd  input  WIDTH  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when hi/lo updated by an operation
div_zero  output  1  last divide had b==0; held until next accepted start
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (reset==0, async): state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; internal accumulators and counter cleared. Reset mid-operation aborts it with no hi/lo update.
- States and transitions:
  - IDLE -> CALC on an edge with start=1.
  - CALC -> FIX after WIDTH iteration edges.
  - FIX -> IDLE on the next edge.
- Accept edge E0 (IDLE, start=1):
  - Latch op.
  - Latch |a| and |b| (magnitudes for signed ops, raw values for unsigned).
  - Latch result signs: qsign = a[W-1]^b[W-1] for signed ops, 0 otherwise; rsign = a[W-1] for signed divide, 0 otherwise.
  - Load count=WIDTH and clear div_zero.
  - busy=1 from after E0.
- CALC, edges E1..EW: one iteration per edge.
  - Multiply: 2W-bit shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract. The remainder keeps W+1 bits so |MIN| is handled.
- FIX, edge E(W+1):
  - Apply two's-complement sign correction: product by qsign; quotient by qsign, remainder by rsign.
  - Write hi/lo and set done=1 for exactly one cycle.
  - busy=0 after E(W+1). Total latency W+1 cycles; 33 for WIDTH=32.
- Sign and width rules:
  - Results are truncated to WIDTH.
  - Signed MIN / -1 gives lo=MIN, hi=0 (no trap).
  - Remainder sign follows the dividend.
- Divide by zero (b==0, DIV or DIVU):
  - Same latency as a normal divide.
  - FIX writes lo = all ones and hi = a (original signed value, not its magnitude).
  - div_zero=1 from FIX until the next accepted start.
- start while busy: ignored; there is no queueing and the requester must hold or retry.
- MTHI/MTLO in IDLE: hi and/or lo take hilo_wd on that edge; both enables may be set together.
- MTHI/MTLO while busy (CALC or FIX): the write is dropped.
- MTHI/MTLO and start on the same IDLE edge: the write is applied and the operation is accepted; FIX later overwrites both registers.
- hi/lo are stable (unchanged) throughout CALC; they change only at FIX, on an MT write, or at reset.
- done is never asserted outside the cycle after FIX.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start one cycle -> busy for 33 cycles; done pulse once; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=7, div_zero=1. Next DIVU 7/2 -> div_zero clears at accept; lo=3, hi=1.
- Start a MULT, then:
  - start=1 and hilo_we_hi=1 (hilo_wd=0x1234) at cycle 5 -> both ignored, result unaffected.
  - reset=0 at cycle 10 -> immediately busy=0, hi=lo=0, no done pulse.
- IDLE with hilo_we_hi=1, hilo_we_lo=1, hilo_wd=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 after the next edge with no done pulse. Repeat with start=1 (MULTU 2*3) on the same edge -> hi=lo=0xA5A5A5A5 after one edge; after FIX, hi=0, lo=6.
